video_timing_gen: RTL and testbench

- Consumes the 108 MHz pixel clock and `locked` flag from the system PLL.
- Generates 1280x1024@60 Hz VESA raster timing: hsync, vsync, data-enable, pixel coordinates and frame/line strobes.
- Feeds the pixel renderer and the VGA output pins.
- Holds the raster idle until the PLL has been continuously locked for a qualification window. Restarts cleanly on lock loss.

---
 rtl/video_timing_gen.sv | 106 ++++++++++
 tb/tb_video_timing_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - VESA raster timing generator gated by PLL lock qualification
module video_timing_gen #(
   parameter int   H_ACTIVE    = 1280,
   parameter int   H_FP        = 48,
   parameter int   H_SYNC      = 112,
   parameter int   H_BP        = 248,
   parameter int   V_ACTIVE    = 1024,
   parameter int   V_FP        = 1,
   parameter int   V_SYNC      = 3,
   parameter int   V_BP        = 38,
   parameter logic HS_POL      = 1'b1,
   parameter logic VS_POL      = 1'b1,
   parameter int   LOCK_CYCLES = 16,
   parameter int   CW          = 11
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pll_locked,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start,
   output logic          running
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int LW      = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   localparam logic [0:0] WAIT_LOCK = 1'b0;
   localparam logic [0:0] RUN       = 1'b1;

   logic [0:0]    state;
   logic [LW-1:0] lock_cnt;
   logic [CW-1:0] h_cnt;
   logic [CW-1:0] v_cnt;

   logic h_act, v_act, hs_act, vs_act, h_last, v_last, lock_done;

   assign h_act     = h_cnt < CW'(H_ACTIVE);
   assign v_act     = v_cnt < CW'(V_ACTIVE);
   assign hs_act    = (h_cnt >= CW'(H_ACTIVE + H_FP)) && (h_cnt < CW'(H_ACTIVE + H_FP + H_SYNC));
   assign vs_act    = (v_cnt >= CW'(V_ACTIVE + V_FP)) && (v_cnt < CW'(V_ACTIVE + V_FP + V_SYNC));
   assign h_last    = h_cnt == CW'(H_TOTAL - 1);
   assign v_last    = v_cnt == CW'(V_TOTAL - 1);
   assign lock_done = lock_cnt == LW'(LOCK_CYCLES - 1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= WAIT_LOCK;
         lock_cnt <= '0;
         h_cnt    <= '0;
         v_cnt    <= '0;
      end else if (state == WAIT_LOCK) begin
         h_cnt <= '0;
         v_cnt <= '0;
         if (!pll_locked) begin
            lock_cnt <= '0;
         end else if (lock_done) begin
            state    <= RUN;
            lock_cnt <= '0;
         end else begin
            lock_cnt <= lock_cnt + 1'b1;
         end
      end else begin
         if (!pll_locked) begin
            state    <= WAIT_LOCK;
            lock_cnt <= '0;
            h_cnt    <= '0;
            v_cnt    <= '0;
         end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   // Outputs decode the pre-edge state and counters, giving exactly one clock of latency.
   always_ff @(posedge clk) begin
      if (!rst_n || state == WAIT_LOCK) begin
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         running     <= 1'b0;
      end else begin
         hsync       <= hs_act ? HS_POL : ~HS_POL;
         vsync       <= vs_act ? VS_POL : ~VS_POL;
         de          <= h_act && v_act;
         x           <= (h_act && v_act) ? h_cnt : '0;
         y           <= (h_act && v_act) ? v_cnt : '0;
         line_start  <= (h_cnt == '0) && v_act;
         frame_start <= (h_cnt == '0) && (v_cnt == '0);
         running     <= 1'b1;
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for default and reduced raster timing
module tb_video_timing_gen;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic [10:0] x;
      logic [10:0] y;
      logic        ls;
      logic        fs;
      logic        run;
   } out_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pll_locked = 1'b0;
   always #5 clk = ~clk;

   logic        hs0, vs0, de0, ls0, fs0, run0;
   logic        hs1, vs1, de1, ls1, fs1, run1;
   logic [10:0] x0, y0, x1, y1;

   video_timing_gen dut_def (
      .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
      .hsync(hs0), .vsync(vs0), .de(de0), .x(x0), .y(y0),
      .line_start(ls0), .frame_start(fs0), .running(run0)
   );

   video_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .LOCK_CYCLES(1)
   ) dut_small (
      .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
      .hsync(hs1), .vsync(vs1), .de(de1), .x(x1), .y(y1),
      .line_start(ls1), .frame_start(fs1), .running(run1)
   );

   out_t got0, got1;
   assign got0 = {hs0, vs0, de0, x0, y0, ls0, fs0, run0};
   assign got1 = {hs1, vs1, de1, x1, y1, ls1, fs1, run1};

   int ha  [2] = '{1280, 8};
   int hfp [2] = '{48, 2};
   int hsw [2] = '{112, 2};
   int hbp [2] = '{248, 2};
   int va  [2] = '{1024, 4};
   int vfp [2] = '{1, 1};
   int vsw [2] = '{3, 1};
   int vbp [2] = '{38, 1};
   int lck [2] = '{16, 1};

   bit     run_m  [2];
   longint t_m    [2];
   int     streak [2];

   out_t q0[$];
   out_t q1[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   bit   started = 0;
   bit   done = 0;

   function automatic out_t idle_out();
      out_t o;
      o = '0;
      return o;
   endfunction

   // Raster position is derived from elapsed RUN time rather than stepped counters.
   function automatic out_t model_out(int k, bit run, longint t);
      out_t   o;
      longint ht, vt, h, v;
      if (!run) return idle_out();
      ht = longint'(ha[k] + hfp[k] + hsw[k] + hbp[k]);
      vt = longint'(va[k] + vfp[k] + vsw[k] + vbp[k]);
      h  = t % ht;
      v  = (t / ht) % vt;
      o.run = 1'b1;
      o.de  = (h < ha[k]) && (v < va[k]);
      o.x   = o.de ? 11'(h) : 11'd0;
      o.y   = o.de ? 11'(v) : 11'd0;
      o.hs  = (h >= ha[k] + hfp[k]) && (h < ha[k] + hfp[k] + hsw[k]);
      o.vs  = (v >= va[k] + vfp[k]) && (v < va[k] + vfp[k] + vsw[k]);
      o.ls  = (h == 0) && (v < va[k]);
      o.fs  = (h == 0) && (v == 0);
      return o;
   endfunction

   task automatic step_model(int k, bit r, bit l);
      if (!r) begin
         run_m[k]  = 0;
         streak[k] = 0;
      end else if (run_m[k]) begin
         if (!l) begin
            run_m[k]  = 0;
            streak[k] = 0;
         end else begin
            t_m[k]++;
         end
      end else if (l) begin
         streak[k]++;
         if (streak[k] == lck[k]) begin
            run_m[k]  = 1;
            t_m[k]    = 0;
            streak[k] = 0;
         end
      end else begin
         streak[k] = 0;
      end
   endtask

   task automatic drive(input bit r, input bit l, input int n);
      out_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst_n      = r;
         pll_locked = l;
         for (int k = 0; k < 2; k++) begin
            e = r ? model_out(k, run_m[k], t_m[k]) : idle_out();
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
            step_model(k, r, l);
         end
         started = 1;
         cyc++;
      end
   endtask

   task automatic check(int k, out_t got, out_t exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL inst%0d cyc%0d: got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b run=%b, expected hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b run=%b",
                  k, cyc, got.hs, got.vs, got.de, got.x, got.y, got.ls, got.fs, got.run,
                  exp.hs, exp.vs, exp.de, exp.x, exp.y, exp.ls, exp.fs, exp.run);
      end
   endtask

   initial begin
      wait (started);
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) check(0, got0, q0.pop_front());
         else if (!done) begin n_cmp++; n_bad++; $display("FAIL inst0 queue empty cyc%0d", cyc); end
         if (q1.size() > 0) check(1, got1, q1.pop_front());
         else if (!done) begin n_cmp++; n_bad++; $display("FAIL inst1 queue empty cyc%0d", cyc); end
      end
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         run_m[k] = 0; t_m[k] = 0; streak[k] = 0;
      end
      drive(0, 0, 4);
      drive(1, 1, 10);
      drive(1, 0, 1);
      drive(1, 1, 6000);
      drive(1, 0, 5);
      drive(1, 1, 4000);
      drive(0, 1, 1);
      drive(1, 1, 2000);
      for (int i = 0; i < 40000; i++)
         drive(($urandom_range(0, 499) != 0), ($urandom_range(0, 299) != 0), 1);
      @(posedge clk);
      #2;
      done = 1;
      n_cmp++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_bad++;
         $display("FAIL drain: left %0d/%0d, expected 0/0", q0.size(), q1.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
